// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with a valid/ready command port and a wait-state timeout
module apb_master #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic [addrWidth-1:0] paddr,
    output logic                 pwrite,
    output logic                 psel,
    output logic                 pen,
    output logic [dataWidth-1:0] pwdata,
    input  logic [dataWidth-1:0] prdata,
    input  logic                 pready
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic                   psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
    logic [addrWidth-1:0]   paddr_q, paddr_d;
    logic [dataWidth-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign pen         = pen_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

    // next-state: accept in IDLE, SETUP->ACCESS, complete on pready or abort once the wait budget is spent
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        pen_d         = pen_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                pen_d   = 1'b1;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                end else if (TIMEOUT != 0 && cnt_q == LAST) begin
                    state_d       = IDLE;
                    psel_d        = 1'b0;
                    pen_d         = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                psel_d  = 1'b0;
                pen_d   = 1'b0;
            end
        endcase
    end

    // state and all bus/response outputs are registered; reset drops the bus and discards any transfer
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            pen_q         <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            pen_q         <= pen_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed vectors plus corner sequences for apb_master against a small APB memory slave
module tb_apb_master;
    logic       pclk = 1'b0;
    logic       prst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_timeout, pwrite, psel, pen, pready;
    logic [7:0] rsp_rdata, paddr, pwdata, prdata;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic [7:0] ws_cnt = 8'h00;
    int         ws_cfg = 0;

    apb_master #(.addrWidth(8), .dataWidth(8), .TIMEOUT(16)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .pen(pen), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 pclk = ~pclk;

    // APB slave: ws_cfg wait states per ACCESS (255 = never ready), byte memory behind it
    assign pready = (int'(ws_cnt) >= ws_cfg);
    assign prdata = mem[paddr];
    always @(posedge pclk) begin
        if (psel && !pen) ws_cnt <= 8'h00;
        else if (psel && pen) ws_cnt <= ws_cnt + 8'h01;
        if (psel && pen && pready && pwrite) mem[paddr] <= pwdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one transfer from IDLE; returns response fields, ACCESS length and accept-to-response latency
    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int ws,
                        output logic [7:0] rd, output logic to, output int pc, output int lat);
        int n = 0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; ws_cfg = ws;
        while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
        chk("accept_bound", 32'(n < 50), 32'd1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_pen", 32'(pen), 32'd0);
        chk("setup_paddr", 32'(paddr), 32'(a));
        chk("setup_pwrite", 32'(pwrite), 32'(w));
        if (w) chk("setup_pwdata", 32'(pwdata), 32'(d));
        pc = 0; lat = 0;
        while (!rsp_valid && lat < 100) begin
            if (pen) pc++;
            @(negedge pclk);
            lat++;
        end
        chk("rsp_bound", 32'(lat < 100), 32'd1);
        rd = rsp_rdata; to = rsp_timeout;
        if (w && !to) shadow[a] = d;
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        int         ws;
        logic [7:0] er;
        logic       et;
        int         ep;
    } vec_t;

    vec_t       vt [9];
    logic [7:0] rd, addrs [256], datas [256];
    logic       to;
    int         pc, lat;

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
        vt[0] = '{1'b1, 8'h12, 8'hA5, 0,   8'h00, 1'b0, 1};
        vt[1] = '{1'b0, 8'h12, 8'h00, 0,   8'hA5, 1'b0, 1};
        vt[2] = '{1'b1, 8'h40, 8'h3C, 1,   8'h00, 1'b0, 2};
        vt[3] = '{1'b0, 8'h40, 8'h00, 3,   8'h3C, 1'b0, 4};
        vt[4] = '{1'b1, 8'h80, 8'h77, 255, 8'h00, 1'b1, 16};
        vt[5] = '{1'b0, 8'h80, 8'h00, 2,   8'h00, 1'b0, 3};
        vt[6] = '{1'b0, 8'h40, 8'h00, 255, 8'h00, 1'b1, 16};
        vt[7] = '{1'b1, 8'hFF, 8'h5A, 0,   8'h00, 1'b0, 1};
        vt[8] = '{1'b0, 8'hFF, 8'h00, 5,   8'h5A, 1'b0, 6};

        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_pen", 32'(pen), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk); @(negedge pclk);
        prst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].ws, rd, to, pc, lat);
            chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(vt[i].er));
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'(vt[i].et));
            chk($sformatf("v%0d_pen_cycles", i), 32'(pc), 32'(vt[i].ep));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].ep + 1));
            chk($sformatf("v%0d_rsp_psel", i), 32'(psel), 32'd0);
            chk($sformatf("v%0d_rsp_pen", i), 32'(pen), 32'd0);
            chk($sformatf("v%0d_rsp_ready", i), 32'(cmd_ready), 32'd1);
            @(negedge pclk);
            chk($sformatf("v%0d_pulse", i), 32'(rsp_valid), 32'd0);
            chk($sformatf("v%0d_rdata_hold", i), 32'(rsp_rdata), 32'(vt[i].er));
        end

        // back-to-back with cmd_valid held: second accept on the first response cycle
        @(negedge pclk);
        ws_cfg = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'h11;
        chk("b2b_ready0", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        chk("b2b_setup_ready", 32'(cmd_ready), 32'd0);
        chk("b2b_setup_psel", 32'(psel), 32'd1);
        @(negedge pclk);
        chk("b2b_access_ready", 32'(cmd_ready), 32'd0);
        chk("b2b_access_pen", 32'(pen), 32'd1);
        @(negedge pclk);
        chk("b2b_rsp1", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp1_ready", 32'(cmd_ready), 32'd1);
        cmd_write = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("b2b_setup2_psel", 32'(psel), 32'd1);
        chk("b2b_setup2_pen", 32'(pen), 32'd0);
        chk("b2b_setup2_pwrite", 32'(pwrite), 32'd0);
        chk("b2b_rsp1_pulse", 32'(rsp_valid), 32'd0);
        @(negedge pclk);
        chk("b2b_access2_pen", 32'(pen), 32'd1);
        @(negedge pclk);
        chk("b2b_rsp2", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp2_rdata", 32'(rsp_rdata), 32'h11);
        chk("b2b_rsp2_timeout", 32'(rsp_timeout), 32'd0);
        shadow[8'h05] = 8'h11;

        // asynchronous reset in the middle of a stalled ACCESS
        @(negedge pclk);
        ws_cfg = 255;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk); @(negedge pclk);
        chk("mid_pen", 32'(pen), 32'd1);
        #2 prst = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_pen", 32'(pen), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        prst = 1'b1;
        begin
            int spur = 0;
            for (int i = 0; i < 20; i++) begin @(negedge pclk); if (rsp_valid || psel) spur++; end
            chk("post_rst_quiet", 32'(spur), 32'd0);
        end

        // memory traffic: 256 random writes, then read each address back
        begin
            int bad = 0, tos = 0;
            for (int i = 0; i < 256; i++) begin
                addrs[i] = 8'($urandom_range(0, 255));
                datas[i] = 8'($urandom_range(0, 255));
                xfer(1'b1, addrs[i], datas[i], int'($urandom_range(0, 2)), rd, to, pc, lat);
                if (to) tos++;
            end
            for (int i = 0; i < 256; i++) begin
                xfer(1'b0, addrs[i], 8'h00, int'($urandom_range(0, 2)), rd, to, pc, lat);
                if (to) tos++;
                if (rd !== shadow[addrs[i]]) begin
                    bad++;
                    if (bad <= 5) chk($sformatf("mem_rd_%0h", addrs[i]), 32'(rd), 32'(shadow[addrs[i]]));
                end
            end
            chk("mem_bad_reads", 32'(bad), 32'd0);
            chk("mem_timeouts", 32'(tos), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers on the peripheral bus. It drives the paddr/pwrite/psel/pen/pwdata bus that the team's APB slave blocks consume. It returns read data, or a write acknowledge, through a one-cycle response pulse. A programmable wait-state timeout aborts transfers whose slave never asserts pready.

## Interface
- addrWidth, 8, APB address width
- dataWidth, 8, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for pready; 0 disables the timeout

Ports:
- pclk  input  1  bus clock; all logic on the rising edge
- prst  input  1  reset; asynchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when high together with cmd_valid at a rising edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  addrWidth  transfer address
- cmd_wdata  input  dataWidth  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  dataWidth  read data; valid with rsp_valid
- rsp_timeout  output  1  transfer aborted by timeout; valid with rsp_valid
- paddr  output  addrWidth  APB address
- pwrite  output  1  APB direction
- psel  output  1  APB select
- pen  output  1  APB enable
- pwdata  output  dataWidth  APB write data
- prdata  input  dataWidth  APB read data
- pready  input  1  APB ready / wait-state control

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, pen=0, cmd_ready=1.
  - On cmd_valid: latch cmd_write/cmd_addr/cmd_wdata into paddr/pwrite/pwdata, then go to SETUP.
- SETUP:
  - psel=1, pen=0, cmd_ready=0.
  - Unconditionally go to ACCESS next cycle; clear the wait counter.
- ACCESS:
  - psel=1, pen=1, cmd_ready=0.
  - pready=1 at the edge: transfer completes.
    - Read: rsp_rdata <= prdata.
    - Write: rsp_rdata <= 0.
    - rsp_timeout <= 0, rsp_valid <= 1, go to IDLE.
  - pready=0: increment the wait counter.
    - If TIMEOUT≠0 and the counter equals TIMEOUT-1: abort with rsp_valid <= 1, rsp_timeout <= 1, rsp_rdata <= 0, go to IDLE.
  - A write that times out may or may not have landed in the slave; the requester treats it as failed.
- Wait counter:
  - Width $clog2(TIMEOUT+1), minimum 1.
  - Never wraps: the transfer ends before the counter can overflow.
- paddr/pwrite/pwdata:
  - Stable from SETUP through the end of ACCESS.
  - Hold their last value in IDLE; no gratuitous toggling.
- Single outstanding transfer only. Commands presented while cmd_ready=0 are ignored; the command source must hold cmd_valid until accepted.

## Timing
- Reset (prst=0, asynchronous): state=IDLE, psel=0, pen=0, paddr=0, pwrite=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, wait counter=0. cmd_ready reads 1.
- Zero-wait-state transfer:
  - Accept edge E0.
  - SETUP cycle E0–E1.
  - ACCESS cycle E1–E2; pready sampled at E2.
  - rsp_valid high E2–E3, with cmd_ready=1 in the same cycle.
  - Next accept at E3 at the earliest, so minimum period is 3 cycles per transfer.
- N wait states add N cycles in ACCESS.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then rsp_valid with rsp_timeout=1.
- rsp_valid:
  - High for exactly one cycle per accepted command.
  - No backpressure.
  - rsp_timeout and rsp_rdata are meaningful only while rsp_valid=1.
  - rsp_rdata holds its value until the next completion.
- pready is ignored outside ACCESS; prdata is ignored except at the completing edge of a read.
- Reset mid-transfer: psel/pen drop immediately, the command is discarded, and no response is issued.

## Test plan
- Reset values: assert prst=0 mid-ACCESS → psel=0, pen=0, rsp_valid=0, cmd_ready=1 asynchronously. After release, no spurious rsp_valid.
- Zero-wait write: addr=0x12, wdata=0xA5, pready tied 1.
  - psel=1/pen=0 for 1 cycle, then psel=1/pen=1 for 1 cycle, with paddr=0x12, pwdata=0xA5, pwrite=1.
  - rsp_valid pulse 2 cycles after accept; rsp_timeout=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x40, pready=0 for 3 ACCESS cycles then 1 with prdata=0x3C.
  - pen high 4 cycles.
  - rsp_rdata=0x3C, rsp_valid single pulse, rsp_timeout=0.
- Timeout: TIMEOUT=16, pready held 0.
  - ACCESS lasts exactly 16 cycles.
  - Then rsp_valid=1, rsp_timeout=1, rsp_rdata=0, and psel/pen return to 0.
- Back-to-back: cmd_valid held high with write 0x05←0x11 then read 0x05.
  - Second accept occurs on the rsp_valid cycle of the first; period 3 cycles.
  - cmd_valid during SETUP/ACCESS is not accepted.
- Write-then-read against an APB memory slave over 256 random addresses: every read returns the last written data; zero timeouts.
